// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_rx
// Description : Oversampled UART 8N1-style command receiver. Delivers the last
//               good byte on cmd_buffer_o with a one-cycle eor_o pulse, or a
//               one-cycle frame_err_o pulse when a frame is discarded.
//               Optional even-parity check enabled by UART_CMD_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_rx #(
   parameter int Width = 8,
   parameter int OvSmp = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             rx_i,
   input  logic             tick_i,
   input  logic             clear_buffer_i,
   output logic [Width-1:0] cmd_buffer_o,
   output logic             eor_o,
   output logic             frame_err_o
);

   localparam int CNT_W = $clog2(OvSmp);
   localparam int BIT_W = $clog2(Width + 1);

   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OvSmp / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OvSmp - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(Width - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic             rx_meta;
   logic             rx_s;
   logic [2:0]       state;
   logic [CNT_W-1:0] tick_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic [Width-1:0] shift_reg;
   logic             par_ok;

   // Two-flop synchronizer for the asynchronous serial pin; idles high.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_s    <= rx_meta;
      end
   end

`ifdef UART_CMD_RX_PARITY_EN
   // Parity result is captured in PARITY and consumed when the stop bit lands.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         par_ok <= 1'b0;
      end else if (tick_i && state == PARITY && tick_cnt == CNT_END) begin
         par_ok <= ~((^shift_reg) ^ rx_s);
      end
   end
`else
   assign par_ok = 1'b1;
`endif

   // Receive FSM, tick/bit counters, shift register and output register.
   // The load is written after the clear so a coinciding load wins.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         tick_cnt     <= '0;
         bit_cnt      <= '0;
         shift_reg    <= '0;
         cmd_buffer_o <= '0;
         eor_o        <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         eor_o       <= 1'b0;
         frame_err_o <= 1'b0;
         if (clear_buffer_i) begin
            cmd_buffer_o <= '0;
         end
         if (tick_i) begin
            case (state)
               IDLE: begin
                  if (!rx_s) begin
                     state    <= START;
                     tick_cnt <= '0;
                  end
               end
               START: begin
                  if (tick_cnt == CNT_MID) begin
                     if (!rx_s) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                     end else begin
                        // Start bit did not hold to mid-bit: treat as a glitch.
                        state <= IDLE;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               DATA: begin
                  if (tick_cnt == CNT_END) begin
                     tick_cnt  <= '0;
                     shift_reg <= {rx_s, shift_reg[Width-1:1]};
                     bit_cnt   <= bit_cnt + 1'b1;
                     if (bit_cnt == BIT_LAST) begin
`ifdef UART_CMD_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
`ifdef UART_CMD_RX_PARITY_EN
               PARITY: begin
                  if (tick_cnt == CNT_END) begin
                     tick_cnt <= '0;
                     state    <= STOP;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
`endif
               STOP: begin
                  if (tick_cnt == CNT_END) begin
                     tick_cnt <= '0;
                     state    <= IDLE;
                     if (rx_s && par_ok) begin
                        cmd_buffer_o <= shift_reg;
                        eor_o        <= 1'b1;
                     end else begin
                        frame_err_o <= 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_rx
// Description : Scoreboard bench for uart_cmd_rx. Each expected pulse (eor or
//               frame error, plus the buffer value it must show) is queued as
//               the frame is driven and retired by the output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_rx;

   localparam int W       = 8;
   localparam int OVS     = 16;
   localparam int TICKDIV = 4;
   localparam int BITCLK  = OVS * TICKDIV;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         rx = 1'b1;
   logic         tick = 1'b0;
   logic         clr = 1'b0;
   logic [W-1:0] cmd_buf;
   logic         eor;
   logic         ferr;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic         err;
      logic [W-1:0] data;
   } exp_t;
   exp_t sb_q[$];

   uart_cmd_rx #(.Width(W), .OvSmp(OVS)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .rx_i          (rx),
      .tick_i        (tick),
      .clear_buffer_i(clr),
      .cmd_buffer_o  (cmd_buf),
      .eor_o         (eor),
      .frame_err_o   (ferr)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Baud tick: one cycle high every TICKDIV clocks, changed on the falling edge
   initial begin
      int tick_div;
      tick_div = 0;
      forever begin
         @(negedge clk);
         tick_div = (tick_div == TICKDIV - 1) ? 0 : tick_div + 1;
         tick = (tick_div == TICKDIV - 1);
      end
   end

   // Output monitor: every pulse must match the head of the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (eor === 1'b1 || ferr === 1'b1) begin
         n_checks++;
         if (eor === 1'b1 && ferr === 1'b1) begin
            n_fail++;
            $display("FAIL pulse_exclusive: eor=%b frame_err=%b, required only one high", eor, ferr);
         end else if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: eor=%b frame_err=%b buf=%h, required no pulse", eor, ferr, cmd_buf);
         end else begin
            e = sb_q.pop_front();
            if (ferr !== e.err || eor !== !e.err || cmd_buf !== e.data) begin
               n_fail++;
               $display("FAIL pulse_result: eor=%b frame_err=%b buf=%h, required eor=%b frame_err=%b buf=%h",
                        eor, ferr, cmd_buf, !e.err, e.err, e.data);
            end
         end
      end
   end

   task automatic line_for(input logic v, input int clocks);
      rx = v;
      repeat (clocks) @(negedge clk);
   endtask

   // Start + data (+ correct even parity) + stop. A low stop bit is released
   // before the receiver could mistake it for a new start bit. With
   // clr_on_load, clear is held across the stop sample until eor appears.
   task automatic send_frame(input logic [W-1:0] d, input logic stop, input logic clr_on_load);
      line_for(1'b0, BITCLK);
      for (int i = 0; i < W; i++) line_for(d[i], BITCLK);
`ifdef UART_CMD_RX_PARITY_EN
      line_for(^d, BITCLK);
`endif
      if (!stop) begin
         line_for(1'b0, BITCLK * 3 / 4);
         line_for(1'b1, BITCLK / 4);
      end else begin
         rx = 1'b1;
         if (clr_on_load) clr = 1'b1;
         for (int k = 0; k < BITCLK; k++) begin
            @(negedge clk);
            if (clr_on_load && clr && eor) begin
               clr = 1'b0;
               n_checks++;
               if (cmd_buf !== d) begin
                  n_fail++;
                  $display("FAIL clear_vs_load: buf=%h, required %h", cmd_buf, d);
               end
            end
         end
         if (clr) begin
            clr = 1'b0;
            n_checks++;
            n_fail++;
            $display("FAIL clear_vs_load_timeout: no eor seen, required eor during stop bit");
         end
      end
   endtask

`ifdef UART_CMD_RX_PARITY_EN
   task automatic send_frame_par(input logic [W-1:0] d, input logic par);
      line_for(1'b0, BITCLK);
      for (int i = 0; i < W; i++) line_for(d[i], BITCLK);
      line_for(par, BITCLK);
      line_for(1'b1, BITCLK);
   endtask
`endif

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d pulses outstanding, required 0", name, sb_q.size());
         sb_q.delete();
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (cmd_buf !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_buf: buf=%h, required 00", cmd_buf);
      end
      n_checks++;
      if (eor !== 1'b0 || ferr !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pulses: eor=%b frame_err=%b, required 0 0", eor, ferr);
      end
      rst = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_rx_byte();
      sb_q.push_back('{err: 1'b0, data: 8'h01});
      send_frame(8'h01, 1'b1, 1'b0);
      wait_drain("rx_byte");
      n_checks++;
      if (cmd_buf !== 8'h01) begin
         n_fail++;
         $display("FAIL rx_byte_buf: buf=%h, required 01", cmd_buf);
      end
   endtask

   task automatic test_glitch();
      line_for(1'b0, 3 * TICKDIV);
      line_for(1'b1, 200);
      n_checks++;
      if (cmd_buf !== 8'h01) begin
         n_fail++;
         $display("FAIL glitch_buf: buf=%h, required 01", cmd_buf);
      end
      // A fresh frame right after the glitch must still be received
      sb_q.push_back('{err: 1'b0, data: 8'h01});
      send_frame(8'h01, 1'b1, 1'b0);
      wait_drain("glitch_recover");
   endtask

   task automatic test_stop_error();
      sb_q.push_back('{err: 1'b1, data: 8'h01});
      send_frame(8'hA5, 1'b0, 1'b0);
      line_for(1'b1, 100);
      wait_drain("stop_error");
      n_checks++;
      if (cmd_buf !== 8'h01) begin
         n_fail++;
         $display("FAIL stop_error_buf: buf=%h, required 01", cmd_buf);
      end
   endtask

   task automatic test_clear();
      sb_q.push_back('{err: 1'b0, data: 8'h3C});
      send_frame(8'h3C, 1'b1, 1'b0);
      wait_drain("clear_rx");
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n_checks++;
      if (cmd_buf !== 8'h00) begin
         n_fail++;
         $display("FAIL clear_buf: buf=%h, required 00", cmd_buf);
      end
   endtask

   task automatic test_clear_vs_load();
      sb_q.push_back('{err: 1'b0, data: 8'h7E});
      send_frame(8'h7E, 1'b1, 1'b1);
      wait_drain("clear_vs_load");
      n_checks++;
      if (cmd_buf !== 8'h7E) begin
         n_fail++;
         $display("FAIL clear_vs_load_hold: buf=%h, required 7E", cmd_buf);
      end
   endtask

   task automatic test_back_to_back();
      sb_q.push_back('{err: 1'b0, data: 8'h55});
      sb_q.push_back('{err: 1'b0, data: 8'hAA});
      send_frame(8'h55, 1'b1, 1'b0);
      send_frame(8'hAA, 1'b1, 1'b0);
      wait_drain("back_to_back");
      n_checks++;
      if (cmd_buf !== 8'hAA) begin
         n_fail++;
         $display("FAIL back_to_back_buf: buf=%h, required AA", cmd_buf);
      end
   endtask

   task automatic test_reset_mid_frame();
      line_for(1'b0, BITCLK);
      for (int i = 0; i < 3; i++) line_for(1'b1, BITCLK);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      line_for(1'b1, 8 * BITCLK);
      n_checks++;
      if (cmd_buf !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_reset_buf: buf=%h, required 00", cmd_buf);
      end
      sb_q.push_back('{err: 1'b0, data: 8'h12});
      send_frame(8'h12, 1'b1, 1'b0);
      wait_drain("mid_reset_frame");
      n_checks++;
      if (cmd_buf !== 8'h12) begin
         n_fail++;
         $display("FAIL mid_reset_buf_after: buf=%h, required 12", cmd_buf);
      end
   endtask

`ifdef UART_CMD_RX_PARITY_EN
   task automatic test_parity();
      sb_q.push_back('{err: 1'b0, data: 8'h03});
      send_frame_par(8'h03, 1'b0);
      wait_drain("parity_good");
      sb_q.push_back('{err: 1'b1, data: 8'h03});
      send_frame_par(8'h03, 1'b1);
      wait_drain("parity_bad");
      n_checks++;
      if (cmd_buf !== 8'h03) begin
         n_fail++;
         $display("FAIL parity_bad_buf: buf=%h, required 03", cmd_buf);
      end
   endtask
`endif

   // Global time limit so the run always ends on its own
   initial begin
      #5ms;
      $display("FAIL watchdog: simulation still running at time limit, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_rx_byte();
      test_glitch();
      test_stop_error();
      test_clear();
      test_clear_vs_load();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef UART_CMD_RX_PARITY_EN
      test_parity();
`endif
      repeat (50) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- Serial command receiver for the measurement controller: UART 8N1-style receiver with oversampling, producing the command byte and end-of-receive pulse.
- Drives the controller's command inputs: cmd_buffer_o feeds its command buffer input and eor_o feeds its end-of-receive input.
- Honours the controller's clear-buffer request. Sits between the board RX pin and the control FSM.

Parameters:
- Width, 8, data bits per frame and width of cmd_buffer_o.
- OvSmp, 16, baud ticks per bit; must be an even number, 4 or greater. The tick counter is clog2(OvSmp) bits wide.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous, active-high reset.
- rx_i  input  1  asynchronous serial line; idles high.
- tick_i  input  1  one-cycle strobe at OvSmp x baud rate.
- clear_buffer_i  input  1  clears cmd_buffer_o.
- cmd_buffer_o  output  Width  last good received byte.
- eor_o  output  1  one-cycle end-of-receive pulse when cmd_buffer_o is updated.
- frame_err_o  output  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset (sync, rst_i high at posedge):
  - state IDLE; tick counter, bit counter and shift register set to 0.
  - Both synchronizer flops set to 1.
  - cmd_buffer_o, eor_o and frame_err_o set to 0.
- Synchronizer:
  - rx_i passes through 2 flops to give rx_s; all decisions use rx_s.
  - Latency from pin to rx_s is 2 clocks.
- Counters:
  - The tick counter advances only on cycles with tick_i high.
  - Clock cycles without tick_i leave all state unchanged, except the clear and pulse logic.
- IDLE:
  - On rx_s == 0: go to START and zero the tick counter.
- START:
  - On the tick where count reaches OvSmp/2-1 (mid start bit):
    - rx_s == 0: zero the counter, zero the bit counter, go to DATA.
    - rx_s == 1: glitch; go to IDLE with no pulse.
- DATA:
  - On the tick where count reaches OvSmp-1:
    - Sample rx_s into the MSB of the shift register, shifting right (line order is LSB first).
    - Zero the counter.
  - After sample number Width, go to STOP (or PARITY when the optional feature is compiled in).
- STOP:
  - On count OvSmp-1, sample rx_s, then return to IDLE.
  - rx_s == 1: on the next posedge, cmd_buffer_o takes the shift register value and eor_o is high for exactly 1 cycle.
  - rx_s == 0: frame_err_o is high for 1 cycle, cmd_buffer_o is unchanged, and eor_o stays low.
  - A new start bit is accepted from the IDLE cycle onward, so back-to-back frames need no gap.
- clear_buffer_i:
  - cmd_buffer_o becomes 0 at the next posedge.
  - If it coincides with a load, the load wins.
  - A clear never affects a frame in progress.
- rst_i mid-frame: the partial frame is dropped silently, with no pulses.
- eor_o and frame_err_o are mutually exclusive and never high in consecutive cycles for the same frame.

Optional Feature:
- Macro: UART_CMD_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, sampled at count OvSmp-1.
  - Even parity: XOR of the data bits and the parity bit must equal 0.
  - On mismatch, the frame still completes its stop bit, then frame_err_o pulses instead of eor_o and cmd_buffer_o is unchanged.
- Undefined:
  - No PARITY state; frame is start + Width data + stop.
  - Only stop-bit errors raise frame_err_o.

Test Plan:
- Receive byte 0x01 (tick_i every 4 clocks, OvSmp 16, correct stop) -> cmd_buffer_o == 0x01; exactly one eor_o pulse; frame_err_o stays 0.
- Low glitch on rx_i of 3 ticks while IDLE -> return to IDLE; no eor_o or frame_err_o; cmd_buffer_o unchanged.
- Byte 0xA5 with stop bit driven 0 -> one frame_err_o pulse, no eor_o, cmd_buffer_o keeps its previous value (0x01).
- Receive 0x3C, then assert clear_buffer_i for 1 cycle -> cmd_buffer_o == 0x00 next cycle.
- Also assert clear_buffer_i in the same cycle as a load of 0x7E -> cmd_buffer_o == 0x7E.
- Back-to-back frames 0x55 and 0xAA with zero idle gap -> two eor_o pulses, buffer values 0x55 then 0xAA.
- Reset asserted mid-DATA of 0xFF, then a clean frame 0x12 -> no pulse for the aborted frame; eor_o with 0x12.
- With UART_CMD_RX_PARITY_EN defined:
  - 0x03 with parity 0 -> eor_o.
  - 0x03 with parity 1 -> frame_err_o only.
